// File: rtl/bist_harness.sv
// Built-in self-test harness: LFSR stimulus into a UUT, MISR compaction of its outputs.
// Optional golden-signature verdict enabled by defining BIST_HARNESS_GOLDEN_CHECK_EN.
module bist_harness #(
  parameter int unsigned       IN_W         = 5,
  parameter int unsigned       OUT_W        = 16,
  parameter int unsigned       NUM_PATTERNS = 256,
  parameter int unsigned       UUT_LAT      = 1,
  parameter int unsigned       UUT_RST_CYC  = 4,
  parameter logic [31:0]       LFSR_SEED    = 32'h1,
  parameter logic [OUT_W-1:0]  MISR_POLY    = OUT_W'(32'h1021),
  localparam int unsigned      CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
  input  logic              bertaClock,
  input  logic              global_reset,
  input  logic              start,
  input  logic [OUT_W-1:0]  golden_sig,
  input  logic [OUT_W-1:0]  uut_out,
  output logic              uut_reset,
  output logic [IN_W-1:0]   uut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [OUT_W-1:0]  signature,
  output logic [CNT_W-1:0]  pattern_cnt
);

  localparam int unsigned TW        = $clog2(UUT_RST_CYC + UUT_LAT + 1);
  localparam logic [31:0] SEED      = (LFSR_SEED == '0) ? 32'h1 : LFSR_SEED;
  localparam int unsigned DRAIN_END = (UUT_LAT == 0) ? 0 : UUT_LAT - 1;

  typedef enum logic [2:0] {IDLE, URST, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_n;
  logic [TW-1:0]     tcnt;
  logic [31:0]       lfsr;
  logic              lfsr_fb;
  logic [OUT_W-1:0]  misr, misr_n;
  logic              valid;
  logic              launch;

  assign launch  = (state_q == IDLE) && start;
  assign lfsr_fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];

  // Valid flag: the RUN flag delayed by the UUT latency, so the MISR only
  // absorbs outputs that correspond to applied vectors.
  generate
    if (UUT_LAT == 0) begin : g_nolat
      assign valid = (state_q == RUN);
    end else begin : g_lat
      logic [UUT_LAT-1:0] vpipe;
      always_ff @(posedge bertaClock) begin
        if (global_reset) begin
          vpipe <= '0;
        end else begin
          vpipe[0] <= (state_q == RUN);
          for (int unsigned i = 1; i < UUT_LAT; i++) begin
            vpipe[i] <= vpipe[i-1];
          end
        end
      end
      assign valid = vpipe[UUT_LAT-1];
    end
  endgenerate

  always_comb begin
    misr_n = misr;
    if (valid) begin
      misr_n = {misr[OUT_W-2:0], 1'b0} ^ (misr[OUT_W-1] ? MISR_POLY : '0) ^ uut_out;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:  if (start) state_n = URST;
      URST:  if (tcnt == TW'(UUT_RST_CYC - 1)) state_n = RUN;
      RUN:   if (pattern_cnt == CNT_W'(NUM_PATTERNS)) state_n = (UUT_LAT == 0) ? DONE : DRAIN;
      DRAIN: if (tcnt == TW'(DRAIN_END)) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge bertaClock) begin
    if (global_reset) begin
      state_q     <= IDLE;
      tcnt        <= '0;
      lfsr        <= '0;
      misr        <= '0;
      uut_reset   <= 1'b0;
      uut_in      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      signature   <= '0;
      pattern_cnt <= '0;
    end else begin
      state_q   <= state_n;
      tcnt      <= (state_n != state_q) ? '0 : tcnt + 1'b1;
      uut_reset <= (state_n == URST);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      if (launch) begin
        misr        <= '0;
        pattern_cnt <= '0;
        signature   <= '0;
        lfsr        <= SEED;
        uut_in      <= '0;
      end else begin
        misr <= misr_n;
        if (state_n == RUN) begin
          uut_in <= lfsr[IN_W-1:0];
          lfsr   <= {lfsr[30:0], lfsr_fb};
          if (pattern_cnt != CNT_W'(NUM_PATTERNS)) pattern_cnt <= pattern_cnt + 1'b1;
        end else begin
          uut_in <= '0;
        end
        if (state_n == DONE) signature <= misr_n;
      end
    end
  end

`ifdef BIST_HARNESS_GOLDEN_CHECK_EN
  always_ff @(posedge bertaClock) begin
    if (global_reset || launch) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (state_n == DONE) begin
      pass <= (misr_n == golden_sig);
      fail <= (misr_n != golden_sig);
    end
  end
`else
  logic unused_golden;
  assign unused_golden = ^golden_sig;
  assign pass = 1'b0;
  assign fail = 1'b0;
`endif

endmodule
